// File: rtl/ldst_unit.sv
// ldst_unit: load/store unit in front of the data memory.
// Stores go through an in-order store buffer that drains to the memory
// write port; loads read the memory combinationally with store-to-load
// forwarding and return through a registered, back-pressurable channel.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake from execute
//   req_we, req_addr, req_wdata   1 = store; word address; store data
//   req_rd                        load destination tag
//   rsp_valid/rsp_ready           response handshake to writeback
//   rsp_data, rsp_rd              load data and its tag
//   drain_en                      store buffer may write memory
//   sb_empty                      store buffer empty
//   tbw_data, dest_addr           memory write data / address
//   wrtEnable                     memory write strobe
//   source_add, outdata           memory read address / read data
module ldst_unit #(
    parameter int SB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_rd,
    input  logic        drain_en,
    output logic        sb_empty,
    output logic [31:0] tbw_data,
    output logic [3:0]  dest_addr,
    output logic        wrtEnable,
    output logic [3:0]  source_add,
    input  logic [31:0] outdata
);

    localparam int AW = $clog2(SB_DEPTH);
    localparam int PW = AW + 1;

    logic [3:0]    sb_addr [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;
    logic [AW-1:0] slot;

    logic          full;
    logic          empty;
    logic          drain;
    logic          st_acc;
    logic          ld_acc;
    logic          ld_req;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [31:0]   ld_data;

    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];
    assign count    = tail - head;
    assign empty    = (head == tail);
    assign full     = (head[AW] != tail[AW]) && (head_idx == tail_idx);

    assign drain    = drain_en & ~empty;
    assign ld_req   = req_valid & ~req_we;

    // A store may enter a full buffer when the head leaves this cycle.
    assign st_acc   = req_valid & req_we & (~full | drain);
    assign ld_acc   = ld_req & (~rsp_valid | rsp_ready);

    assign req_ready = req_we ? (~full | drain) : (~rsp_valid | rsp_ready);

    assign sb_empty   = empty;
    assign wrtEnable  = drain;
    assign dest_addr  = empty ? 4'd0 : sb_addr[head_idx];
    assign tbw_data   = empty ? 32'd0 : sb_data[head_idx];
    assign source_add = ld_req ? req_addr : 4'd0;

    // Walk oldest to youngest so the youngest matching entry wins.
    // The entry draining this cycle is still included.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        slot     = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            slot = head_idx + AW'(i);
            if ((PW'(i) < count) && (sb_addr[slot] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[slot];
            end
        end
    end

    assign ld_data = fwd_hit ? fwd_data : outdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (drain) begin
                head <= head + PW'(1);
            end
            if (st_acc) begin
                tail <= tail + PW'(1);
            end
        end
    end

    // Entry storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (st_acc) begin
            sb_addr[tail_idx] <= req_addr;
            sb_data[tail_idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_rd    <= 4'd0;
        end else if (ld_acc) begin
            rsp_valid <= 1'b1;
            rsp_data  <= ld_data;
            rsp_rd    <= req_rd;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ldst_unit.sv
// tb_ldst_unit: directed and randomized bench for ldst_unit.
// A queue-based reference model predicts handshakes, writes and responses.
module tb_ldst_unit;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_rd;
    logic        drain_en;
    logic        sb_empty;
    logic [31:0] tbw_data;
    logic [3:0]  dest_addr;
    logic        wrtEnable;
    logic [3:0]  source_add;
    logic [31:0] outdata;

    ldst_unit #(.SB_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .drain_en(drain_en), .sb_empty(sb_empty),
        .tbw_data(tbw_data), .dest_addr(dest_addr),
        .wrtEnable(wrtEnable), .source_add(source_add),
        .outdata(outdata)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    logic [31:0] mem [16];
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
        end else if (wrtEnable) begin
            mem[dest_addr] <= tbw_data;
        end
    end

    assign outdata = mem[source_add];

    // Reference model: pending stores in program order, memory image,
    // and the response slot.
    logic [35:0] sbq [$];
    logic [31:0] refmem [16];
    bit          m_rv;
    logic [31:0] m_rdata;
    logic [3:0]  m_rrd;

    int pass_cnt = 0;
    int total    = 0;

    function automatic bit exp_ready();
        if (req_we) return (sbq.size() < D) || (drain_en && sbq.size() > 0);
        return !m_rv || rsp_ready;
    endfunction

    function automatic bit exp_wen();
        return drain_en && (sbq.size() > 0);
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_rv    = 1'b0;
        m_rdata = 32'd0;
        m_rrd   = 4'd0;
    endtask

    // Advance one clock edge, updating the model from the current inputs.
    task automatic tick();
        bit          dr;
        bit          sa;
        bit          la;
        logic [31:0] ld;
        dr = exp_wen();
        sa = req_valid && req_we && exp_ready();
        la = req_valid && !req_we && exp_ready();
        ld = refmem[req_addr];
        foreach (sbq[i]) if (sbq[i][35:32] == req_addr) ld = sbq[i][31:0];
        @(posedge clk);
        if (dr) begin
            refmem[sbq[0][35:32]] = sbq[0][31:0];
            sbq.delete(0);
        end
        if (sa) sbq.push_back({req_addr, req_wdata});
        if (la) begin
            m_rv    = 1'b1;
            m_rdata = ld;
            m_rrd   = req_rd;
        end else if (rsp_ready) begin
            m_rv = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input bit v, input bit we, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] rd);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_rd    = rd;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        mem_init  = 1'b1;
        drain_en  = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        for (int i = 0; i < 16; i++) refmem[i] = 32'(i);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); else pass_cnt++;
        total++; if (rsp_data !== 32'd0) $display("FAIL rst_rsp_data got %h want 0", rsp_data); else pass_cnt++;
        total++; if (rsp_rd !== 4'd0) $display("FAIL rst_rsp_rd got %0d want 0", rsp_rd); else pass_cnt++;
        total++; if (wrtEnable !== 1'b0) $display("FAIL rst_wen got %0b want 0", wrtEnable); else pass_cnt++;
        total++; if (sb_empty !== 1'b1) $display("FAIL rst_sb_empty got %0b want 1", sb_empty); else pass_cnt++;
        total++; if (dest_addr !== 4'd0) $display("FAIL rst_dest_addr got %0d want 0", dest_addr); else pass_cnt++;
        total++; if (tbw_data !== 32'd0) $display("FAIL rst_tbw_data got %h want 0", tbw_data); else pass_cnt++;
        total++; if (source_add !== 4'd0) $display("FAIL rst_source_add got %0d want 0", source_add); else pass_cnt++;
        rst      = 1'b0;
        mem_init = 1'b0;
    endtask

    task automatic test_forward();
        drain_en  = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'd0);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL fwd_st_ready got %0b want 1", req_ready); else pass_cnt++;
        total++; if (wrtEnable !== 1'b0) $display("FAIL fwd_wen0 got %0b want 0", wrtEnable); else pass_cnt++;
        tick();
        set_req(1'b1, 1'b0, 4'd3, 32'd0, 4'd5);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL fwd_ld_ready got %0b want 1", req_ready); else pass_cnt++;
        total++; if (wrtEnable !== 1'b1) $display("FAIL fwd_wen1 got %0b want 1", wrtEnable); else pass_cnt++;
        total++; if (dest_addr !== 4'd3) $display("FAIL fwd_dest got %0d want 3", dest_addr); else pass_cnt++;
        total++; if (tbw_data !== 32'hDEADBEEF) $display("FAIL fwd_wdata got %h want deadbeef", tbw_data); else pass_cnt++;
        total++; if (source_add !== 4'd3) $display("FAIL fwd_src got %0d want 3", source_add); else pass_cnt++;
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL fwd_rsp_valid got %0b want 1", rsp_valid); else pass_cnt++;
        total++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL fwd_rsp_data got %h want deadbeef", rsp_data); else pass_cnt++;
        total++; if (rsp_rd !== 4'd5) $display("FAIL fwd_rsp_rd got %0d want 5", rsp_rd); else pass_cnt++;
        total++; if (mem[3] !== 32'hDEADBEEF) $display("FAIL fwd_mem3 got %h want deadbeef", mem[3]); else pass_cnt++;
        total++; if (sb_empty !== 1'b1) $display("FAIL fwd_empty got %0b want 1", sb_empty); else pass_cnt++;
        tick();
    endtask

    task automatic test_youngest();
        int writes;
        drain_en  = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, 4'd1, 32'd10, 4'd0);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL yng_st1_ready got %0b want 1", req_ready); else pass_cnt++;
        tick();
        set_req(1'b1, 1'b1, 4'd1, 32'd20, 4'd0);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL yng_st2_ready got %0b want 1", req_ready); else pass_cnt++;
        tick();
        set_req(1'b1, 1'b1, 4'd1, 32'd30, 4'd0);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL yng_st3_ready got %0b want 0", req_ready); else pass_cnt++;
        tick();
        set_req(1'b1, 1'b0, 4'd1, 32'd0, 4'd2);
        @(negedge clk);
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        drain_en = 1'b1;
        writes   = 0;
        @(negedge clk);
        total++; if (rsp_data !== 32'd20) $display("FAIL yng_rsp_data got %0d want 20", rsp_data); else pass_cnt++;
        total++; if (rsp_rd !== 4'd2) $display("FAIL yng_rsp_rd got %0d want 2", rsp_rd); else pass_cnt++;
        if (wrtEnable === 1'b1) writes++;
        tick();
        repeat (3) begin
            @(negedge clk);
            if (wrtEnable === 1'b1) writes++;
            tick();
        end
        total++; if (writes != 2) $display("FAIL yng_writes got %0d want 2", writes); else pass_cnt++;
        total++; if (mem[1] !== 32'd20) $display("FAIL yng_mem1 got %0d want 20", mem[1]); else pass_cnt++;
        total++; if (sb_empty !== 1'b1) $display("FAIL yng_empty got %0b want 1", sb_empty); else pass_cnt++;
    endtask

    task automatic test_hold();
        drain_en  = 1'b1;
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b0, 4'd7, 32'd0, 4'd9);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL hold_ld1_ready got %0b want 1", req_ready); else pass_cnt++;
        tick();
        set_req(1'b1, 1'b0, 4'd4, 32'd0, 4'd6);
        repeat (3) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b1) $display("FAIL hold_valid got %0b want 1", rsp_valid); else pass_cnt++;
            total++; if (rsp_data !== 32'd7) $display("FAIL hold_data got %0d want 7", rsp_data); else pass_cnt++;
            total++; if (rsp_rd !== 4'd9) $display("FAIL hold_rd got %0d want 9", rsp_rd); else pass_cnt++;
            total++; if (req_ready !== 1'b0) $display("FAIL hold_ld2_blocked got %0b want 0", req_ready); else pass_cnt++;
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL hold_ld2_ready got %0b want 1", req_ready); else pass_cnt++;
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        @(negedge clk);
        total++; if (rsp_data !== 32'd4) $display("FAIL hold_ld2_data got %0d want 4", rsp_data); else pass_cnt++;
        total++; if (rsp_rd !== 4'd6) $display("FAIL hold_ld2_rd got %0d want 6", rsp_rd); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        localparam int N = 2 * D + 1;
        logic [31:0] wd [N];
        logic [35:0] gotw [$];
        int          k;
        int          cyc;
        bit          acc;
        for (int i = 0; i < N; i++) wd[i] = $urandom;
        rsp_ready = 1'b1;
        k   = 0;
        cyc = 0;
        while ((k < N || sbq.size() > 0) && cyc < 60) begin
            drain_en = (k < N) ? (cyc % 2 == 0) : 1'b1;
            if (k < N) set_req(1'b1, 1'b1, 4'(11 + k), wd[k], 4'd0);
            else set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
            @(negedge clk);
            if (wrtEnable === 1'b1) gotw.push_back({dest_addr, tbw_data});
            if (k < N) begin
                total++; if (req_ready !== exp_ready()) $display("FAIL b2b_ready cyc %0d got %0b want %0b", cyc, req_ready, exp_ready()); else pass_cnt++;
            end
            total++; if (sb_empty !== (sbq.size() == 0)) $display("FAIL b2b_empty cyc %0d got %0b want %0b", cyc, sb_empty, sbq.size() == 0); else pass_cnt++;
            acc = (k < N) && exp_ready();
            tick();
            if (acc) k++;
            cyc++;
        end
        total++; if (cyc >= 60) $display("FAIL b2b_timeout got %0d cycles want <60", cyc); else pass_cnt++;
        total++; if (gotw.size() != N) $display("FAIL b2b_nwrites got %0d want %0d", gotw.size(), N); else pass_cnt++;
        for (int i = 0; i < N && i < gotw.size(); i++) begin
            total++; if (gotw[i] !== {4'(11 + i), wd[i]}) $display("FAIL b2b_write%0d got %h want %h", i, gotw[i], {4'(11 + i), wd[i]}); else pass_cnt++;
        end
        @(negedge clk);
        total++; if (sb_empty !== 1'b1) $display("FAIL b2b_final_empty got %0b want 1", sb_empty); else pass_cnt++;
        tick();
    endtask

    task automatic test_full_drain();
        drain_en  = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b1, 1'b1, 4'd2, 32'hA, 4'd0);
        @(negedge clk);
        tick();
        set_req(1'b1, 1'b1, 4'd2, 32'hB, 4'd0);
        @(negedge clk);
        tick();
        set_req(1'b1, 1'b1, 4'd5, 32'hC, 4'd0);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL full_blocked got %0b want 0", req_ready); else pass_cnt++;
        total++; if (sb_empty !== 1'b0) $display("FAIL full_empty got %0b want 0", sb_empty); else pass_cnt++;
        tick();
        drain_en = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL full_drain_ready got %0b want 1", req_ready); else pass_cnt++;
        total++; if (wrtEnable !== 1'b1) $display("FAIL full_drain_wen got %0b want 1", wrtEnable); else pass_cnt++;
        total++; if (dest_addr !== 4'd2) $display("FAIL full_drain_dest got %0d want 2", dest_addr); else pass_cnt++;
        tick();
        drain_en = 1'b0;
        set_req(1'b1, 1'b1, 4'd6, 32'hD, 4'd0);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL full_still_full got %0b want 0", req_ready); else pass_cnt++;
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        drain_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        total++; if (sb_empty !== 1'b1) $display("FAIL full_final_empty got %0b want 1", sb_empty); else pass_cnt++;
        total++; if (mem[2] !== 32'hB) $display("FAIL full_mem2 got %h want b", mem[2]); else pass_cnt++;
        total++; if (mem[5] !== 32'hC) $display("FAIL full_mem5 got %h want c", mem[5]); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int writes;
        drain_en  = 1'b0;
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, 4'd9, 32'h1111, 4'd0);
        @(negedge clk);
        tick();
        set_req(1'b1, 1'b1, 4'd10, 32'h2222, 4'd0);
        @(negedge clk);
        tick();
        set_req(1'b1, 1'b0, 4'd0, 32'd0, 4'd3);
        @(negedge clk);
        tick();
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL rmid_pending got %0b want 1", rsp_valid); else pass_cnt++;
        total++; if (sb_empty !== 1'b0) $display("FAIL rmid_buffered got %0b want 0", sb_empty); else pass_cnt++;
        rst = 1'b1;
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rmid_rsp_valid got %0b want 0", rsp_valid); else pass_cnt++;
        total++; if (rsp_data !== 32'd0) $display("FAIL rmid_rsp_data got %h want 0", rsp_data); else pass_cnt++;
        total++; if (rsp_rd !== 4'd0) $display("FAIL rmid_rsp_rd got %0d want 0", rsp_rd); else pass_cnt++;
        total++; if (sb_empty !== 1'b1) $display("FAIL rmid_empty got %0b want 1", sb_empty); else pass_cnt++;
        total++; if (dest_addr !== 4'd0) $display("FAIL rmid_dest got %0d want 0", dest_addr); else pass_cnt++;
        total++; if (tbw_data !== 32'd0) $display("FAIL rmid_wdata got %h want 0", tbw_data); else pass_cnt++;
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        drain_en  = 1'b1;
        rsp_ready = 1'b1;
        writes    = 0;
        repeat (4) begin
            @(negedge clk);
            if (wrtEnable === 1'b1) writes++;
            tick();
        end
        total++; if (writes != 0) $display("FAIL rmid_writes got %0d want 0", writes); else pass_cnt++;
        total++; if (mem[9] !== 32'd9) $display("FAIL rmid_mem9 got %h want 9", mem[9]); else pass_cnt++;
        total++; if (mem[10] !== 32'd10) $display("FAIL rmid_mem10 got %h want a", mem[10]); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            drain_en  = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            total++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready c%0d got %0b want %0b", c, req_ready, exp_ready()); else pass_cnt++;
            total++; if (wrtEnable !== exp_wen()) $display("FAIL rnd_wen c%0d got %0b want %0b", c, wrtEnable, exp_wen()); else pass_cnt++;
            if (exp_wen()) begin
                total++; if ({dest_addr, tbw_data} !== sbq[0]) $display("FAIL rnd_write c%0d got %h want %h", c, {dest_addr, tbw_data}, sbq[0]); else pass_cnt++;
            end
            total++; if (rsp_valid !== m_rv) $display("FAIL rnd_rsp_valid c%0d got %0b want %0b", c, rsp_valid, m_rv); else pass_cnt++;
            if (m_rv) begin
                total++; if (rsp_data !== m_rdata) $display("FAIL rnd_rsp_data c%0d got %h want %h", c, rsp_data, m_rdata); else pass_cnt++;
                total++; if (rsp_rd !== m_rrd) $display("FAIL rnd_rsp_rd c%0d got %0d want %0d", c, rsp_rd, m_rrd); else pass_cnt++;
            end
            total++; if (sb_empty !== (sbq.size() == 0)) $display("FAIL rnd_empty c%0d got %0b want %0b", c, sb_empty, sbq.size() == 0); else pass_cnt++;
            tick();
        end
        set_req(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        drain_en  = 1'b1;
        rsp_ready = 1'b1;
        repeat (D + 2) begin
            @(negedge clk);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            total++; if (mem[i] !== refmem[i]) $display("FAIL rnd_mem%0d got %h want %h", i, mem[i], refmem[i]); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_youngest();
        test_hold();
        test_back_to_back();
        test_full_drain();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/ldst_unit.md
# ldst_unit

Load/store unit sitting directly upstream of the data memory. Accepts one memory operation per cycle from the execute stage over a valid/ready handshake. Buffers stores in an in-order store buffer that drains to the memory's write port. Services loads through the memory's combinational read port, with store-to-load forwarding, and returns load results to writeback over a registered, back-pressurable response channel.

## Interface
- SB_DEPTH, 2: store buffer entries (power of two, 2..8)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute presents an operation
- req_ready  out  1  unit accepts the operation this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  4  word address
- req_wdata  in  32  signed store data
- req_rd  in  4  load destination register tag
- rsp_valid  out  1  load result available
- rsp_ready  in  1  writeback consumes result
- rsp_data  out  32  signed load data
- rsp_rd  out  4  tag of the returned load
- drain_en  in  1  1 = store buffer may write memory this cycle
- sb_empty  out  1  store buffer empty (fence/flush status)
- tbw_data  out  32  memory write data
- dest_addr  out  4  memory write address
- wrtEnable  out  1  memory write strobe
- source_add  out  4  memory read address
- outdata  in  32  memory read data (combinational from source_add)

## Operation
- Store buffer: circular FIFO of SB_DEPTH {addr, data}. Head and tail pointers carry one extra wrap bit. Full = pointers equal except wrap bit; empty = fully equal.
- Store accept: req_valid & req_we & (not full, or a drain in the same cycle). Entry is written at the tail.
- Drain: when drain_en and not empty, combinationally drive dest_addr/tbw_data = head entry and wrtEnable = 1; head advances at the clock edge. Otherwise wrtEnable = 0, and dest_addr/tbw_data show the head entry (don't-care).
- Load accept: req_valid & ~req_we & (~rsp_valid | rsp_ready). source_add = req_addr whenever a load is presented.
- Forwarding: load data = youngest valid buffer entry whose addr matches. Entries include the one draining this cycle. If no entry matches, use outdata.
- Simultaneous store accept and drain in the same cycle is legal at full; the count is unchanged.
- A store and a load cannot be presented in the same cycle, because there is a single request channel.
- Response register: on load accept, rsp_valid <= 1 and rsp_data/rsp_rd are captured. Otherwise, if rsp_ready, rsp_valid <= 0. Data holds stable while rsp_valid & ~rsp_ready.
- req_ready = req_we ? (~full | drain) : (~rsp_valid | rsp_ready). It depends on req_we, which is legal because execute holds req_* stable while valid.
- Reset mid-operation: buffered stores are discarded and never written; a pending response is dropped.

## Timing
- Reset values: rsp_valid 0, rsp_data 0, rsp_rd 0, wrtEnable 0, sb_empty 1, head = tail = 0. With an empty buffer, dest_addr, tbw_data and source_add read 0.
- Store latency: the earliest memory write happens in the cycle after accept, with wrtEnable high during that cycle and the data committed at the following edge.
- Load latency: rsp_valid rises 1 cycle after accept. Loads can be sustained one per cycle while rsp_ready = 1.
- Forwarding has zero bubble: a load accepted in the cycle right after a store to the same address returns the store data.
- Throughput: one store per cycle while drain_en = 1. With drain_en = 0, exactly SB_DEPTH stores are accepted, and then req_ready = 0 for stores.
- Pointer wrap: pointers wrap modulo 2*SB_DEPTH, and no entry is lost across the wrap.

## Test plan
- Reset, then store addr 3 = 0xDEADBEEF, then load addr 3 with rd 5 -> forwarded rsp_data 0xDEADBEEF and rsp_rd 5, one cycle after load accept; memory word 3 = 0xDEADBEEF after the drain.
- drain_en = 0, stores to addr 1 = 10 and addr 1 = 20 -> third store sees req_ready = 0. A load of addr 1 returns 20 (youngest match). After drain_en = 1, wrtEnable is high for 2 cycles, and memory word 1 = 20.
- Load addr 7 with an empty buffer (memory init word 7 = 7) -> rsp_data 7. Hold rsp_ready = 0 for 3 cycles -> rsp_valid stays 1, data stays stable, and a second load sees req_ready = 0.
- Back-to-back stores across 2*SB_DEPTH+1 operations with drain_en toggling -> every write occurs in order and count ≤ SB_DEPTH; sb_empty = 1 at the end.
- Assert rst while 2 stores are buffered and a response is pending -> all outputs return to reset values immediately, and no write happens afterwards.
- Buffer full with drain_en = 1 and a store presented -> accepted in the same cycle as the drain, and the count stays at SB_DEPTH.
